// File: rtl/fprobus_wait_bridge_if.sv
// MCS IO-bus / FPro-bus signal bundle for fprobus_wait_bridge.
//   slave  : the bridge's view (consumes MCS requests and slot responses,
//            drives MCS completion and slot requests)
//   master : the environment's view (MCS plus attached slots)
interface fprobus_wait_bridge_if #(
  parameter int unsigned NUM_CS = 2,
  parameter int unsigned ADDR_W = 21
);
  // MCS IO bus
  logic              io_addr_strobe;
  logic              io_read_strobe;
  logic              io_write_strobe;
  logic [3:0]        io_byte_enable;
  logic [31:0]       io_address;
  logic [31:0]       io_write_data;
  logic [31:0]       io_read_data;
  logic              io_ready;
  // FPro slot bus
  logic [NUM_CS-1:0] fp_cs;
  logic              fp_wr;
  logic              fp_rd;
  logic [ADDR_W-1:0] fp_word_addr;
  logic [1:0]        fp_byte_addr;
  logic [3:0]        fp_byte_en;
  logic [31:0]       fp_wr_data;
  logic [31:0]       fp_rd_data;
  logic              fp_ready;
  // Status
  logic              err_timeout;

  modport slave (
    input  io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable,
           io_address, io_write_data, fp_rd_data, fp_ready,
    output io_read_data, io_ready, fp_cs, fp_wr, fp_rd, fp_word_addr,
           fp_byte_addr, fp_byte_en, fp_wr_data, err_timeout
  );

  modport master (
    output io_addr_strobe, io_read_strobe, io_write_strobe, io_byte_enable,
           io_address, io_write_data, fp_rd_data, fp_ready,
    input  io_read_data, io_ready, fp_cs, fp_wr, fp_rd, fp_word_addr,
           fp_byte_addr, fp_byte_en, fp_wr_data, err_timeout
  );
endinterface

// File: rtl/fprobus_wait_bridge.sv
// MCS IO-bus to FPro-bus bridge with NUM_CS decoded slots, byte enables,
// fp_ready wait states and a timeout watchdog that always returns io_ready.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : fprobus_wait_bridge_if.slave (MCS request/response side,
//                slot select/strobe/data side, sticky err_timeout)
// All bus outputs are registered.
module fprobus_wait_bridge #(
  parameter logic [31:0] BRG_BASE = 32'hc000_0000,
  parameter int unsigned NUM_CS   = 2,
  parameter int unsigned ADDR_W   = 21,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fprobus_wait_bridge_if.slave  bus
);

  localparam int unsigned CS_W  = $clog2(NUM_CS);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CS-1:0]  cs_q, cs_d;
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic [1:0]         byte_q, byte_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               strobe;
  logic               hit;
  logic [CS_W-1:0]    slot;
  logic               last_cycle;

  assign strobe     = bus.io_read_strobe | bus.io_write_strobe;
  assign hit        = (bus.io_address[31:24] == BRG_BASE[31:24]);
  assign slot       = bus.io_address[23 -: CS_W];
  assign last_cycle = (cnt_q == CNT_W'(TIMEOUT - 1));

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.io_addr_strobe, bus.io_address};

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      is_wr_q <= 1'b0;
      word_q  <= '0;
      byte_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      is_wr_q <= is_wr_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    is_wr_d = is_wr_q;
    word_d  = word_q;
    byte_d  = byte_q;
    be_d    = be_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (hit) begin
            // write strobe takes priority when both are raised together
            is_wr_d = bus.io_write_strobe;
            word_d  = bus.io_address[ADDR_W+1:2];
            byte_d  = bus.io_address[1:0];
            be_d    = bus.io_byte_enable;
            wdata_d = bus.io_write_data;
            cs_d    = NUM_CS'(1) << slot;
            wr_d    = bus.io_write_strobe;
            rd_d    = ~bus.io_write_strobe;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            // unmapped address: complete immediately and flag it
            if (!bus.io_write_strobe) rdata_d = 32'h0000_0000;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      ACCESS: begin
        if (bus.fp_ready) begin
          // a response in the final cycle still beats the watchdog
          if (!is_wr_q) rdata_d = bus.fp_rd_data;
          cnt_d   = '0;
          cs_d    = '0;
          ready_d = 1'b1;
          state_d = DONE;
        end else if (last_cycle) begin
          if (!is_wr_q) rdata_d = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          cnt_d   = '0;
          cs_d    = '0;
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_d    = '0;
      end
    endcase
  end

  assign bus.io_read_data = rdata_q;
  assign bus.io_ready     = ready_q;
  assign bus.fp_cs        = cs_q;
  assign bus.fp_wr        = wr_q;
  assign bus.fp_rd        = rd_q;
  assign bus.fp_word_addr = word_q;
  assign bus.fp_byte_addr = byte_q;
  assign bus.fp_byte_en   = be_q;
  assign bus.fp_wr_data   = wdata_q;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_fprobus_wait_bridge.sv
// Self-checking bench: two bridges (NUM_CS = 2 and 4) receive identical MCS
// stimulus; each has its own slot model answering after a chosen number of
// wait cycles. Expectations come from a transaction-level model.
module tb_fprobus_wait_bridge;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned ADDR_W  = 21;
  localparam int          WIN     = TIMEOUT + 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fprobus_wait_bridge_if #(.NUM_CS(2), .ADDR_W(ADDR_W)) b2 ();
  fprobus_wait_bridge_if #(.NUM_CS(4), .ADDR_W(ADDR_W)) b4 ();

  fprobus_wait_bridge #(.BRG_BASE(32'hc000_0000), .NUM_CS(2), .ADDR_W(ADDR_W),
                        .TIMEOUT(TIMEOUT))
    dut2 (.clk(clk), .reset(reset), .bus(b2));

  fprobus_wait_bridge #(.BRG_BASE(32'hc000_0000), .NUM_CS(4), .ADDR_W(ADDR_W),
                        .TIMEOUT(TIMEOUT))
    dut4 (.clk(clk), .reset(reset), .bus(b4));

  int n_checks = 0;
  int n_errors = 0;

  // model state shared by both bridges
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_io(input logic rs, input logic ws, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
    b2.io_read_strobe = rs;  b4.io_read_strobe = rs;
    b2.io_write_strobe = ws; b4.io_write_strobe = ws;
    b2.io_address = addr;    b4.io_address = addr;
    b2.io_byte_enable = be;  b4.io_byte_enable = be;
    b2.io_write_data = wd;   b4.io_write_data = wd;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs2"},    32'(b2.fp_cs), 32'h0);
    check({tag, "_cs4"},    32'(b4.fp_cs), 32'h0);
    check({tag, "_ready2"}, 32'(b2.io_ready), 32'h0);
    check({tag, "_ready4"}, 32'(b4.io_ready), 32'h0);
    check({tag, "_err2"},   32'(b2.err_timeout), 32'(exp_err));
    check({tag, "_err4"},   32'(b4.err_timeout), 32'(exp_err));
    check({tag, "_rdata2"}, b2.io_read_data, exp_rdata);
    check({tag, "_rdata4"}, b4.io_read_data, exp_rdata);
  endtask

  // One MCS transaction; the slot answers wait_n cycles after its first
  // selected cycle (wait_n >= TIMEOUT means never).
  task automatic run_txn(input string tag, input logic rs, input logic ws,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int wait_n, input bit restrobe);
    bit hit;
    int exp_lat;
    logic [1:0] exp_cs2;
    logic [3:0] exp_cs4;
    int lat2, lat4, rdy2, rdy4, acc2, acc4, rdp2, rdp4, wrp2, wrp4;
    logic [1:0] cs_or2;
    logic [3:0] cs_or4;
    logic [31:0] word_s, be_s, wd_s, ba_s;

    hit     = (addr[31:24] == 8'hc0);
    exp_lat = !hit ? 1 : (wait_n < int'(TIMEOUT) ? wait_n + 2 : int'(TIMEOUT) + 1);
    exp_cs2 = hit ? (2'b01 << addr[23]) : 2'b00;
    exp_cs4 = hit ? (4'b0001 << addr[23:22]) : 4'b0000;
    if (!hit || wait_n >= int'(TIMEOUT)) exp_err = 1'b1;
    if (!ws) begin
      if (!hit)                          exp_rdata = 32'h0000_0000;
      else if (wait_n >= int'(TIMEOUT))  exp_rdata = 32'hFFFF_FFFF;
      else                               exp_rdata = rd;
    end

    lat2 = -1; lat4 = -1; rdy2 = 0; rdy4 = 0; acc2 = 0; acc4 = 0;
    rdp2 = 0; rdp4 = 0; wrp2 = 0; wrp4 = 0; cs_or2 = '0; cs_or4 = '0;
    word_s = '0; be_s = '0; wd_s = '0; ba_s = '0;

    @(negedge clk);
    drive_io(rs, ws, addr, be, wd);
    b2.fp_rd_data = rd; b4.fp_rd_data = rd;
    b2.fp_ready = 1'($urandom_range(0, 1));
    b4.fp_ready = 1'($urandom_range(0, 1));

    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (k == 1) drive_io(1'b0, 1'b0, addr, be, wd);
      if (restrobe && k == 2) begin b2.io_read_strobe = 1'b1; b4.io_read_strobe = 1'b1; end
      if (restrobe && k == 3) begin b2.io_read_strobe = 1'b0; b4.io_read_strobe = 1'b0; end
      if (b2.fp_rd) rdp2++;
      if (b4.fp_rd) rdp4++;
      if (b2.fp_wr) wrp2++;
      if (b4.fp_wr) wrp4++;
      cs_or2 |= b2.fp_cs;
      cs_or4 |= b4.fp_cs;
      if (b2.fp_cs != 0 && acc2 == 0) begin
        word_s = 32'(b2.fp_word_addr); be_s = 32'(b2.fp_byte_en);
        wd_s = b2.fp_wr_data;          ba_s = 32'(b2.fp_byte_addr);
      end
      if (b2.io_ready) begin rdy2++; if (lat2 < 0) lat2 = k; end
      if (b4.io_ready) begin rdy4++; if (lat4 < 0) lat4 = k; end
      // slot responses for this cycle; random noise while not selected
      b2.fp_ready = (b2.fp_cs != 0) ? (acc2 == wait_n) : 1'($urandom_range(0, 1));
      b4.fp_ready = (b4.fp_cs != 0) ? (acc4 == wait_n) : 1'($urandom_range(0, 1));
      if (b2.fp_cs != 0) acc2++;
      if (b4.fp_cs != 0) acc4++;
    end
    b2.fp_ready = 1'b0; b4.fp_ready = 1'b0;

    check({tag, "_lat2"},   32'(lat2), 32'(exp_lat));
    check({tag, "_lat4"},   32'(lat4), 32'(exp_lat));
    check({tag, "_nrdy2"},  32'(rdy2), 32'd1);
    check({tag, "_nrdy4"},  32'(rdy4), 32'd1);
    check({tag, "_cs2"},    32'(cs_or2), 32'(exp_cs2));
    check({tag, "_cs4"},    32'(cs_or4), 32'(exp_cs4));
    check({tag, "_cscyc2"}, 32'(acc2), 32'(hit ? exp_lat - 1 : 0));
    check({tag, "_cscyc4"}, 32'(acc4), 32'(hit ? exp_lat - 1 : 0));
    check({tag, "_rdp2"},   32'(rdp2), 32'(hit && !ws));
    check({tag, "_rdp4"},   32'(rdp4), 32'(hit && !ws));
    check({tag, "_wrp2"},   32'(wrp2), 32'(hit && ws));
    check({tag, "_wrp4"},   32'(wrp4), 32'(hit && ws));
    if (hit) begin
      check({tag, "_word"},  word_s, 32'(addr[ADDR_W+1:2]));
      check({tag, "_baddr"}, ba_s, 32'(addr[1:0]));
      check({tag, "_be"},    be_s, 32'(be));
      check({tag, "_wdata"}, wd_s, wd);
    end
    check({tag, "_rdata2"}, b2.io_read_data, exp_rdata);
    check({tag, "_rdata4"}, b4.io_read_data, exp_rdata);
    check({tag, "_err2"},   32'(b2.err_timeout), 32'(exp_err));
    check({tag, "_err4"},   32'(b4.err_timeout), 32'(exp_err));
  endtask

  initial begin
    int rdy;
    int w;
    logic [31:0] a;
    logic ws;

    reset = 1'b1;
    b2.io_addr_strobe = 1'b0; b4.io_addr_strobe = 1'b0;
    drive_io(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    b2.fp_rd_data = '0; b4.fp_rd_data = '0;
    b2.fp_ready = 1'b0; b4.fp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_rd2", 32'(b2.fp_rd | b2.fp_wr), 32'h0);
    check("reset_word2", 32'(b2.fp_word_addr), 32'h0);
    reset = 1'b0;

    run_txn("zw_read",  1'b1, 1'b0, 32'hc000_0010, 4'hF, 32'h0, 32'h1234_5678, 0, 1'b0);
    run_txn("ws_write", 1'b0, 1'b1, 32'hc080_0008, 4'b0011, 32'hA5A5_0F0F, 32'h0, 3, 1'b0);
    run_txn("timeout",  1'b1, 1'b0, 32'hc000_0040, 4'hF, 32'h0, 32'h0BAD_0BAD, 99, 1'b0);
    run_txn("miss",     1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'h5555_5555, 0, 1'b0);
    run_txn("both_stb", 1'b1, 1'b1, 32'hc000_0100, 4'hF, 32'hCAFE_F00D, 32'h0, 1, 1'b0);
    run_txn("restrobe", 1'b1, 1'b0, 32'hc0C0_0004, 4'hF, 32'h0, 32'h0C0C_0C0C, 3, 1'b1);
    run_txn("last_rdy", 1'b1, 1'b0, 32'hc040_0020, 4'hF, 32'h0, 32'h7777_1111,
            int'(TIMEOUT) - 1, 1'b0);

    // reset in the second cycle of a stalled access
    @(negedge clk);
    drive_io(1'b1, 1'b0, 32'hc000_0020, 4'hF, 32'h0);
    @(negedge clk);
    drive_io(1'b0, 1'b0, 32'hc000_0020, 4'hF, 32'h0);
    check("rst_mid_cs_before", 32'(b2.fp_cs), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err = 1'b0;
    exp_rdata = 32'h0;
    check_idle_outputs("rst_mid");
    rdy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (b2.io_ready || b4.io_ready) rdy++;
    end
    check("rst_mid_no_ready", 32'(rdy), 32'h0);
    run_txn("post_rst", 1'b1, 1'b0, 32'hc000_0010, 4'hF, 32'h0, 32'h1234_5678, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) a = {8'hc0, 24'($urandom)};
      else begin
        a = $urandom;
        if (a[31:24] == 8'hc0) a[31:24] = 8'h40;
      end
      case ($urandom_range(0, 9))
        7:       w = int'(TIMEOUT) - 1;
        8:       w = int'(TIMEOUT);
        9:       w = 40;
        default: w = int'($urandom_range(0, 5));
      endcase
      ws = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", i), ~ws | 1'($urandom_range(0, 1)), ws, a,
              4'($urandom), $urandom, $urandom, w, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
